multicycle_controller: RTL and testbench

//  Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder. Sequences each instruction through

---
 rtl/multicycle_controller_pkg.sv | 114 +++++++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_op_decode.sv | 56 +++++
 rtl/multicycle_controller.sv | 128 ++++++++++++
 tb/tb_multicycle_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU codes,
// FSM states, decoded instruction class and the registered control bundle.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_MULTU   = 6'b011001;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_XOR     = 6'b100110;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;

    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_AND   = 6'b100100;
    localparam logic [5:0] ALU_OR    = 6'b100101;
    localparam logic [5:0] ALU_XOR   = 6'b100110;
    localparam logic [5:0] ALU_SLT   = 6'b101010;
    localparam logic [5:0] ALU_LUI   = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MULDIV, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_ALU_R, C_ALU_I, C_LOAD, C_STORE,
        C_BRANCH, C_MULDIV, C_J, C_JAL, C_SYSCALL
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [5:0] alu_op;
        logic       alu_src;
        logic       mem_byte;
    } dec_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_branch;
        logic       ir_write;
        logic       mem_req;
        logic       mem_write_en;
        logic       mem_byte;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [5:0] alu_op;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic logic [5:0] imm_alu_op(input logic [5:0] op);
        logic [5:0] r;
        case (op)
            OP_ADDIU: r = ALU_ADDU;
            OP_SLTI:  r = ALU_SLT;
            OP_ANDI:  r = ALU_AND;
            OP_ORI:   r = ALU_OR;
            OP_XORI:  r = ALU_XOR;
            OP_LUI:   r = ALU_LUI;
            default:  r = ALU_ADD;
        endcase
        return r;
    endfunction

    // rt selects BGEZ (1) / BLTZ (0) under REGIMM
    function automatic logic br_taken(input logic [5:0] op, input logic rt,
                                      input logic zero, input logic neg);
        logic t;
        case (op)
            OP_BEQ:    t = zero;
            OP_BNE:    t = ~zero;
            OP_BLEZ:   t = neg | zero;
            OP_BGTZ:   t = ~neg & ~zero;
            OP_REGIMM: t = rt ? ~neg : neg;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> IR/datapath/memory bundle. The controller takes the master view,
// the datapath side (or a bench) the slave view.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       rt_field;
    logic       alu_zero;
    logic       alu_neg;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_branch;
    logic       ir_write;
    logic       mem_req;
    logic       mem_write_en;
    logic       mem_byte;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [5:0] alu_op;
    logic       halted;
    logic       illegal;

    modport master (
        input  opcode, func, rt_field, alu_zero, alu_neg, mem_ready,
        output pc_write, pc_branch, ir_write, mem_req, mem_write_en, mem_byte,
               reg_dst, reg_write, mem_to_reg, alu_src, alu_op, halted, illegal
    );

    modport slave (
        output opcode, func, rt_field, alu_zero, alu_neg, mem_ready,
        input  pc_write, pc_branch, ir_write, mem_req, mem_write_en, mem_byte,
               reg_dst, reg_write, mem_to_reg, alu_src, alu_op, halted, illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_op_decode.sv
// Combinational instruction decode: opcode/func -> instruction class, ALU function
// code, immediate-operand select and byte-access flag. Unknown encodings decode as C_ILLEGAL.
module multicycle_controller_alu_op_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '{cls: C_ILLEGAL, alu_op: 6'd0, alu_src: 1'b0, mem_byte: 1'b0};
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: begin
                        dec_o.cls    = C_ALU_R;
                        dec_o.alu_op = func_i;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        dec_o.cls    = C_MULDIV;
                        dec_o.alu_op = func_i;
                    end
                    F_SYSCALL: dec_o.cls = C_SYSCALL;
                    default: ;
                endcase
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec_o.cls    = C_BRANCH;
                dec_o.alu_op = ALU_SUB;
            end
            OP_J:   dec_o.cls = C_J;
            OP_JAL: dec_o.cls = C_JAL;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_o.cls     = C_ALU_I;
                dec_o.alu_op  = imm_alu_op(opcode_i);
                dec_o.alu_src = 1'b1;
            end
            OP_LB, OP_LW: begin
                dec_o.cls      = C_LOAD;
                dec_o.alu_op   = ALU_ADD;
                dec_o.alu_src  = 1'b1;
                dec_o.mem_byte = (opcode_i == OP_LB);
            end
            OP_SB, OP_SW: begin
                dec_o.cls      = C_STORE;
                dec_o.alu_op   = ALU_ADD;
                dec_o.alu_src  = 1'b1;
                dec_o.mem_byte = (opcode_i == OP_SB);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MULDIV/MEM/WB/HALT). Every output is a
// register loaded with the control word of the state being entered.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_controller_if.master  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            out_q, out_d;
    dec_t             dec;
    logic             mem_done;
    logic             taken;

    multicycle_controller_alu_op_decode u_dec (
        .opcode_i (bus.opcode),
        .func_i   (bus.func),
        .dec_o    (dec)
    );

    // A ready seen while no request is outstanding never completes an access.
    assign mem_done = out_q.mem_req & (bus.mem_ready | (MEM_HANDSHAKE == 0));
    assign taken    = br_taken(bus.opcode, bus.rt_field, bus.alu_zero, bus.alu_neg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH:  if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    C_J, C_ILLEGAL: state_d = S_FETCH;
                    C_JAL:          state_d = S_WB;
                    C_SYSCALL:      state_d = S_HALT;
                    default:        state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (dec.cls)
                    C_MULDIV: begin
                        state_d = S_MULDIV;
                        cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = S_FETCH;
                    default:         state_d = S_WB;
                endcase
            end
            S_MULDIV: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_MEM:    if (mem_done) state_d = (dec.cls == C_STORE) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Fetch-cycle pulses (jump, branch, illegal) are tagged by the state being left.
    always_comb begin
        out_d = '0;
        case (state_d)
            S_FETCH: begin
                out_d.mem_req   = 1'b1;
                out_d.pc_write  = (state_q == S_DECODE) && (dec.cls == C_J);
                out_d.pc_branch = (state_q == S_EXEC) && (dec.cls == C_BRANCH) && taken;
                out_d.illegal   = (state_q == S_DECODE) && (dec.cls == C_ILLEGAL);
            end
            S_DECODE: begin
                out_d.ir_write = 1'b1;
                out_d.pc_write = 1'b1;
            end
            S_EXEC: begin
                out_d.alu_op  = dec.alu_op;
                out_d.alu_src = dec.alu_src;
            end
            S_MULDIV: out_d.alu_op = dec.alu_op;
            S_MEM: begin
                out_d.mem_req      = 1'b1;
                out_d.mem_write_en = (dec.cls == C_STORE);
                out_d.mem_byte     = dec.mem_byte;
            end
            S_WB: begin
                out_d.reg_write  = 1'b1;
                out_d.reg_dst    = (dec.cls == C_ALU_R);
                out_d.mem_to_reg = (dec.cls == C_LOAD);
                out_d.pc_write   = (dec.cls == C_JAL);
            end
            S_HALT:  out_d.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_write     = out_q.pc_write;
    assign bus.pc_branch    = out_q.pc_branch;
    assign bus.ir_write     = out_q.ir_write;
    assign bus.mem_req      = out_q.mem_req;
    assign bus.mem_write_en = out_q.mem_write_en;
    assign bus.mem_byte     = out_q.mem_byte;
    assign bus.reg_dst      = out_q.reg_dst;
    assign bus.reg_write    = out_q.reg_write;
    assign bus.mem_to_reg   = out_q.mem_to_reg;
    assign bus.alu_src      = out_q.alu_src;
    assign bus.alu_op       = out_q.alu_op;
    assign bus.halted       = out_q.halted;
    assign bus.illegal      = out_q.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each instruction
// into its expected per-cycle control words; randomized waits and ALU flags.
module tb_multicycle_controller;

    localparam int MDC = 4;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_MD = 5,
                   K_J = 6, K_JAL = 7, K_SYS = 8, K_ILL = 9;
    localparam int NT = 40;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [5:0] aop;
        logic       byt;
    } ent_t;

    ent_t tbl [NT];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.MULDIV_CYCLES(MDC), .CNT_W(6), .MEM_HANDSHAKE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk = 0;
    int   n_bad = 0;
    logic pend_pcw, pend_pcb, pend_ill;
    logic [17:0] obs;

    assign obs = {bus.pc_write, bus.pc_branch, bus.ir_write, bus.mem_req, bus.mem_write_en,
                  bus.mem_byte, bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.alu_src,
                  bus.alu_op, bus.halted, bus.illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] ev(input logic pcw, pcb, irw, mrq, mwe, mby, rdst, rw, m2r,
                                       asrc, input logic [5:0] aop, input logic hlt, ill);
        return {pcw, pcb, irw, mrq, mwe, mby, rdst, rw, m2r, asrc, aop, hlt, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic br_ok(input logic [5:0] op, input logic rt, input logic z, input logic n);
        case (op)
            6'h04:   return z;
            6'h05:   return !z;
            6'h06:   return n || z;
            6'h07:   return !n && !z;
            6'h01:   return rt ? !n : n;
            default: return 1'b0;
        endcase
    endfunction

    // Check this cycle's outputs, drive this cycle's inputs, advance to #1 after next edge.
    task automatic step(input string tag, input logic [17:0] exp, input logic rdy,
                        input logic z, input logic n);
        chk(tag, {14'd0, obs}, {14'd0, exp});
        bus.mem_ready = rdy;
        bus.alu_zero  = z;
        bus.alu_neg   = n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_state", {14'd0, obs}, 32'd0);
        rst = 1'b0;
        pend_pcw = 1'b0; pend_pcb = 1'b0; pend_ill = 1'b0;
        step("post_rst", 18'd0, rb(), rb(), rb());
    endtask

    task automatic gen(input int idx, input int fw, input int mw, input logic z,
                       input logic n, input logic rt);
        ent_t e;
        e = tbl[idx];
        bus.opcode   = e.op;
        bus.func     = (e.op == 6'h00) ? e.fn : 6'($urandom);
        bus.rt_field = rt;
        for (int i = 0; i <= fw; i++) begin
            if (i == 0) step("fetch", ev(pend_pcw, pend_pcb, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 0, pend_ill),
                             (i == fw), rb(), rb());
            else        step("fetch_wait", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0),
                             (i == fw), rb(), rb());
        end
        pend_pcw = 1'b0; pend_pcb = 1'b0; pend_ill = 1'b0;
        step("decode", ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0), rb(), rb(), rb());
        case (e.kind)
            K_J:   pend_pcw = 1'b1;
            K_ILL: pend_ill = 1'b1;
            K_SYS: begin
                for (int i = 0; i < 20; i++)
                    step("halt", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 1, 0), rb(), rb(), rb());
                do_reset();
            end
            K_JAL: step("wb_jal", ev(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 0, 0), rb(), rb(), rb());
            default: begin
                step("exec", ev(0, 0, 0, 0, 0, 0, 0, 0, 0,
                                (e.kind == K_I || e.kind == K_LD || e.kind == K_ST),
                                e.aop, 0, 0), rb(), z, n);
                case (e.kind)
                    K_BR: pend_pcb = br_ok(e.op, rt, z, n);
                    K_MD: for (int i = 0; i < MDC; i++)
                              step("muldiv", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e.aop, 0, 0),
                                   rb(), rb(), rb());
                    K_LD, K_ST: begin
                        for (int i = 0; i <= mw; i++)
                            step("mem", ev(0, 0, 0, 1, (e.kind == K_ST), e.byt, 0, 0, 0, 0, 6'd0, 0, 0),
                                 (i == mw), rb(), rb());
                        if (e.kind == K_LD)
                            step("wb_load", ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'd0, 0, 0), rb(), rb(), rb());
                    end
                    default: step("wb_alu", ev(0, 0, 0, 0, 0, 0, (e.kind == K_R), 1, 0, 0, 6'd0, 0, 0),
                                  rb(), rb(), rb());
                endcase
            end
        endcase
    endtask

    initial begin
        tbl = '{
            '{6'h00, 6'h20, K_R, 6'h20, 1'b0}, '{6'h00, 6'h21, K_R, 6'h21, 1'b0},
            '{6'h00, 6'h22, K_R, 6'h22, 1'b0}, '{6'h00, 6'h23, K_R, 6'h23, 1'b0},
            '{6'h00, 6'h24, K_R, 6'h24, 1'b0}, '{6'h00, 6'h25, K_R, 6'h25, 1'b0},
            '{6'h00, 6'h26, K_R, 6'h26, 1'b0}, '{6'h00, 6'h27, K_R, 6'h27, 1'b0},
            '{6'h00, 6'h2a, K_R, 6'h2a, 1'b0}, '{6'h00, 6'h2b, K_R, 6'h2b, 1'b0},
            '{6'h00, 6'h00, K_R, 6'h00, 1'b0}, '{6'h00, 6'h02, K_R, 6'h02, 1'b0},
            '{6'h00, 6'h03, K_R, 6'h03, 1'b0},
            '{6'h00, 6'h18, K_MD, 6'h18, 1'b0}, '{6'h00, 6'h19, K_MD, 6'h19, 1'b0},
            '{6'h00, 6'h1a, K_MD, 6'h1a, 1'b0}, '{6'h00, 6'h1b, K_MD, 6'h1b, 1'b0},
            '{6'h00, 6'h0c, K_SYS, 6'h00, 1'b0},
            '{6'h08, 6'h00, K_I, 6'h20, 1'b0}, '{6'h09, 6'h00, K_I, 6'h21, 1'b0},
            '{6'h0a, 6'h00, K_I, 6'h2a, 1'b0}, '{6'h0c, 6'h00, K_I, 6'h24, 1'b0},
            '{6'h0d, 6'h00, K_I, 6'h25, 1'b0}, '{6'h0e, 6'h00, K_I, 6'h26, 1'b0},
            '{6'h0f, 6'h00, K_I, 6'h3f, 1'b0},
            '{6'h20, 6'h00, K_LD, 6'h20, 1'b1}, '{6'h23, 6'h00, K_LD, 6'h20, 1'b0},
            '{6'h28, 6'h00, K_ST, 6'h20, 1'b1}, '{6'h2b, 6'h00, K_ST, 6'h20, 1'b0},
            '{6'h04, 6'h00, K_BR, 6'h22, 1'b0}, '{6'h05, 6'h00, K_BR, 6'h22, 1'b0},
            '{6'h06, 6'h00, K_BR, 6'h22, 1'b0}, '{6'h07, 6'h00, K_BR, 6'h22, 1'b0},
            '{6'h01, 6'h00, K_BR, 6'h22, 1'b0},
            '{6'h02, 6'h00, K_J, 6'h00, 1'b0}, '{6'h03, 6'h00, K_JAL, 6'h00, 1'b0},
            '{6'h3f, 6'h00, K_ILL, 6'h00, 1'b0}, '{6'h00, 6'h01, K_ILL, 6'h00, 1'b0},
            '{6'h0b, 6'h00, K_ILL, 6'h00, 1'b0}, '{6'h00, 6'h3f, K_ILL, 6'h00, 1'b0}
        };
        bus.opcode = 6'h00; bus.func = 6'h00; bus.rt_field = 1'b0;
        bus.alu_zero = 1'b0; bus.alu_neg = 1'b0; bus.mem_ready = 1'b0;
        do_reset();

        // reset in the middle of a stalled LW access
        bus.opcode = 6'h23; bus.func = 6'h00;
        step("fetch", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0), 1'b1, 1'b0, 1'b0);
        step("decode", ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0), 1'b0, 1'b0, 1'b0);
        step("exec", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h20, 0, 0), 1'b0, 1'b0, 1'b0);
        step("mem", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0), 1'b0, 1'b0, 1'b0);
        step("mem", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_state", {14'd0, obs}, 32'd0);
        rst = 1'b0;
        pend_pcw = 1'b0; pend_pcb = 1'b0; pend_ill = 1'b0;
        step("post_rst", 18'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_fetch", {14'd0, obs}, {14'd0, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0)});

        gen(0, 0, 0, 1'b0, 1'b0, 1'b0);    // ADD, no stalls
        gen(26, 0, 3, 1'b0, 1'b0, 1'b0);   // LW, 3-cycle memory stall
        gen(29, 0, 0, 1'b1, 1'b0, 1'b0);   // BEQ taken
        gen(29, 1, 0, 1'b0, 1'b0, 1'b0);   // BEQ not taken
        gen(13, 0, 0, 1'b0, 1'b0, 1'b0);   // MULT
        gen(36, 0, 0, 1'b0, 1'b0, 1'b0);   // undefined opcode
        gen(17, 0, 0, 1'b0, 1'b0, 1'b0);   // SYSCALL, then reset

        for (int k = 0; k < 400; k++)
            gen($urandom_range(0, NT - 1), $urandom_range(0, 2), $urandom_range(0, 3),
                rb(), rb(), rb());
        gen(0, 0, 0, 1'b0, 1'b0, 1'b0);    // flush pending fetch-cycle pulses

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
